// File: rtl/sys_bus_pkg.sv
// ---------------------------------------------------------------------------
// sys_bus_pkg
// Shared types and constants for the two-requester system bus arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default address / data widths
//   state_t                 : arbiter FSM states
//   req_id_t                : requester identifier (0 or 1)
//   ERR_DATA                : read data returned when a transaction is aborted
//   pick_grant()            : round-robin grant selection
// ---------------------------------------------------------------------------
package sys_bus_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic req_id_t;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    // With both requesters pending, the one that was not served last wins.
    function automatic req_id_t pick_grant(input logic pend0, input logic pend1,
                                           input req_id_t last_grant);
        if (pend0 && pend1) begin
            return ~last_grant;
        end else if (pend0) begin
            return 1'b0;
        end else begin
            return 1'b1;
        end
    endfunction

endpackage

// File: rtl/sys_bus_arbiter_req_latch.sv
// ---------------------------------------------------------------------------
// req_latch
// Captures one outstanding request from a cache requester.
//   clk, rst            : clock, synchronous active-high reset
//   strobe              : one-cycle request pulse
//   rw_in, address_in,
//   data_in             : request fields sampled with the strobe
//   clear               : request has completed (arbiter DONE for this side)
//   pending             : a captured request is waiting / in service
//   rw, address, data   : captured request fields
// ---------------------------------------------------------------------------
module req_latch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic              rw_in,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear,
    output logic              pending,
    output logic              rw,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data
);

    // A strobe arriving in the same cycle the old request retires is taken
    // as the next request; otherwise strobes while pending are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            rw      <= 1'b0;
            address <= '0;
            data    <= '0;
        end else if (strobe && (!pending || clear)) begin
            pending <= 1'b1;
            rw      <= rw_in;
            address <= address_in;
            data    <= data_in;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sys_bus_arbiter
// Shares the backing-memory system bus between two cache requesters with
// round-robin grant, one memory transaction at a time.
//   clk, rst                      : clock, synchronous active-high reset
//   reqN_strobe/rw/address/data_in: one-cycle request from requester N
//   reqN_ready                    : one-cycle completion pulse to requester N
//   reqN_data_out                 : last read data for requester N
//   sysstrobe/sysrw/sysaddress/
//   sysdata_out                   : request to memory
//   sysdata_in, sysready          : memory response (sampled only in WAIT)
//   timeout_err                   : abort pulse, coincident with reqN_ready
// Build option: define TIMEOUT_EN to enable the WAIT watchdog (TIMEOUT
// cycles); without it WAIT is unbounded and timeout_err stays 0.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transaction; grant a pending requester and drive the bus
// ISSUE | sysstrobe high for this single cycle
// WAIT  | bus fields held; waiting for sysready (or watchdog expiry)
// DONE  | reqG_ready high; granted latch is cleared, last_grant updated
// ---------------------------------------------------------------------------
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_strobe,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_address,
    input  logic [DATA_W-1:0] req0_data_in,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_data_out,
    input  logic              req1_strobe,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_address,
    input  logic [DATA_W-1:0] req1_data_in,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_data_out,
    output logic              sysstrobe,
    output logic              sysrw,
    output logic [ADDR_W-1:0] sysaddress,
    output logic [DATA_W-1:0] sysdata_out,
    input  logic [DATA_W-1:0] sysdata_in,
    input  logic              sysready,
    output logic              timeout_err
);

    state_t  state;
    req_id_t grant;
    req_id_t last_grant;
    req_id_t nxt_grant;

    logic              pend0, pend1;
    logic              lat0_rw, lat1_rw;
    logic [ADDR_W-1:0] lat0_address, lat1_address;
    logic [DATA_W-1:0] lat0_data, lat1_data;
    logic              clr0, clr1;

    logic              tmo_hit;
    logic              wait_done;
    logic [DATA_W-1:0] cpl_data;

    assign clr0 = (state == DONE) && (grant == 1'b0);
    assign clr1 = (state == DONE) && (grant == 1'b1);

    req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_latch0 (
        .clk        (clk),
        .rst        (rst),
        .strobe     (req0_strobe),
        .rw_in      (req0_rw),
        .address_in (req0_address),
        .data_in    (req0_data_in),
        .clear      (clr0),
        .pending    (pend0),
        .rw         (lat0_rw),
        .address    (lat0_address),
        .data       (lat0_data)
    );

    req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_latch1 (
        .clk        (clk),
        .rst        (rst),
        .strobe     (req1_strobe),
        .rw_in      (req1_rw),
        .address_in (req1_address),
        .data_in    (req1_data_in),
        .clear      (clr1),
        .pending    (pend1),
        .rw         (lat1_rw),
        .address    (lat1_address),
        .data       (lat1_data)
    );

    assign nxt_grant = pick_grant(pend0, pend1, last_grant);

`ifdef TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Down-counter loaded on entry to WAIT; terminal count means TIMEOUT
    // WAIT cycles have elapsed without sysready.
    assign tmo_hit = (state == WAIT) && (wait_cnt == '0) && !sysready;
`else
    assign tmo_hit = 1'b0;
`endif

    assign wait_done = sysready || tmo_hit;
    assign cpl_data  = tmo_hit ? DATA_W'(ERR_DATA) : sysdata_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            sysstrobe     <= 1'b0;
            sysrw         <= 1'b0;
            sysaddress    <= '0;
            sysdata_out   <= '0;
            req0_ready    <= 1'b0;
            req1_ready    <= 1'b0;
            req0_data_out <= '0;
            req1_data_out <= '0;
            timeout_err   <= 1'b0;
`ifdef TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            sysstrobe   <= 1'b0;
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (pend0 || pend1) begin
                        grant       <= nxt_grant;
                        sysstrobe   <= 1'b1;
                        sysrw       <= nxt_grant ? lat1_rw      : lat0_rw;
                        sysaddress  <= nxt_grant ? lat1_address : lat0_address;
                        sysdata_out <= nxt_grant ? lat1_data    : lat0_data;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef TIMEOUT_EN
                    wait_cnt <= CNT_W'(TIMEOUT - 1);
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (wait_done) begin
                        state       <= DONE;
                        timeout_err <= tmo_hit;
                        if (grant == 1'b0) begin
                            req0_ready <= 1'b1;
                            if (sysrw) req0_data_out <= cpl_data;
                        end else begin
                            req1_ready <= 1'b1;
                            if (sysrw) req1_data_out <= cpl_data;
                        end
                    end
`ifdef TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
`endif
                end
                DONE: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
module tb_sys_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_strobe, req0_rw, req0_ready;
    logic [AW-1:0] req0_address;
    logic [DW-1:0] req0_data_in, req0_data_out;
    logic          req1_strobe, req1_rw, req1_ready;
    logic [AW-1:0] req1_address;
    logic [DW-1:0] req1_data_in, req1_data_out;
    logic          sysstrobe, sysrw, sysready, timeout_err;
    logic [AW-1:0] sysaddress;
    logic [DW-1:0] sysdata_out, sysdata_in;

    always #5 clk = ~clk;

    sys_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_strobe   (req0_strobe),
        .req0_rw       (req0_rw),
        .req0_address  (req0_address),
        .req0_data_in  (req0_data_in),
        .req0_ready    (req0_ready),
        .req0_data_out (req0_data_out),
        .req1_strobe   (req1_strobe),
        .req1_rw       (req1_rw),
        .req1_address  (req1_address),
        .req1_data_in  (req1_data_in),
        .req1_ready    (req1_ready),
        .req1_data_out (req1_data_out),
        .sysstrobe     (sysstrobe),
        .sysrw         (sysrw),
        .sysaddress    (sysaddress),
        .sysdata_out   (sysdata_out),
        .sysdata_in    (sysdata_in),
        .sysready      (sysready),
        .timeout_err   (timeout_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } sys_exp_t;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] dout;
        logic          err;
    } cpl_exp_t;

    sys_exp_t sys_q[$];
    cpl_exp_t cpl_q[$];
    int       strobe_cyc_q[$];
    int       ready_cyc_q[$];
    int       n_sys = 0;
    int       n_rdy = 0;
    logic [DW-1:0] exp_dout [2];

    task automatic exp_sys(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        sys_exp_t e;
        e.rw = rw; e.addr = a; e.wdata = d;
        sys_q.push_back(e);
    endtask

    // Reads update the requester's modelled data_out; writes leave it alone.
    task automatic exp_cpl(input logic id, input logic rw, input logic [DW-1:0] rdata, input logic err);
        cpl_exp_t e;
        if (rw) exp_dout[id] = rdata;
        e.id = id; e.dout = exp_dout[id]; e.err = err;
        cpl_q.push_back(e);
    endtask

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [logic [AW-1:0]];
    bit            mem_auto     = 1'b1;
    int            mem_delay    = 1;
    bit            manual_pulse = 1'b0;
    logic [DW-1:0] manual_data  = '0;
    int            stable_err   = 0;

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    initial begin
        bit            busy = 1'b0;
        int            cnt  = 0;
        logic [AW-1:0] m_addr = '0;
        logic          m_rw = 1'b0;
        sysready   = 1'b0;
        sysdata_in = '0;
        forever begin
            @(negedge clk);
            sysready = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else if (manual_pulse) begin
                sysready     = 1'b1;
                sysdata_in   = manual_data;
                manual_pulse = 1'b0;
            end else if (busy) begin
                if (sysaddress !== m_addr || sysrw !== m_rw) stable_err++;
                if (cnt == 0) begin
                    sysready   = 1'b1;
                    sysdata_in = m_rw ? mem_rd(m_addr) : 32'h0;
                    busy       = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (sysstrobe && mem_auto) begin
                m_addr = sysaddress;
                m_rw   = sysrw;
                busy   = 1'b1;
                cnt    = mem_delay - 1;
                if (!sysrw) mem[sysaddress] = sysdata_out;
            end
        end
    end

    // ---------------- monitors ----------------
    initial begin
        sys_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && sysstrobe) begin
                n_sys++;
                strobe_cyc_q.push_back(cyc);
                if (sys_q.size() == 0) begin
                    chk("sys_unexpected", 32'(sysstrobe), 32'h0);
                end else begin
                    e = sys_q.pop_front();
                    chk("sysrw", 32'(sysrw), 32'(e.rw));
                    chk("sysaddress", 32'(sysaddress), 32'(e.addr));
                    if (!e.rw) chk("sysdata_out", sysdata_out, e.wdata);
                end
            end
        end
    end

    initial begin
        cpl_exp_t   e;
        logic [1:0] rdy;
        logic [1:0] prev_rdy = 2'b00;
        forever begin
            @(negedge clk);
            rdy = {req1_ready, req0_ready};
            if (rdy != 2'b00) begin
                n_rdy++;
                ready_cyc_q.push_back(cyc);
                chk("ready_width", 32'(prev_rdy), 32'h0);
                if (cpl_q.size() == 0) begin
                    chk("ready_unexpected", 32'(rdy), 32'h0);
                end else begin
                    e = cpl_q.pop_front();
                    chk("ready_id", 32'(rdy), e.id ? 32'h2 : 32'h1);
                    chk("data_out", e.id ? req1_data_out : req0_data_out, e.dout);
                    chk("timeout_err", 32'(timeout_err), 32'(e.err));
                end
            end else if (timeout_err) begin
                chk("timeout_err_alone", 32'(timeout_err), 32'h0);
            end
            prev_rdy = rdy;
        end
    end

    // ---------------- stimulus helpers ----------------
    int issue_cyc = 0;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_dout[0] = '0;
        exp_dout[1] = '0;
    endtask

    task automatic strobe(input logic id, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        if (id) begin
            req1_strobe = 1'b1; req1_rw = rw; req1_address = a; req1_data_in = d;
        end else begin
            req0_strobe = 1'b1; req0_rw = rw; req0_address = a; req0_data_in = d;
        end
        issue_cyc = cyc;
        @(negedge clk);
        req0_strobe = 1'b0;
        req1_strobe = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (sys_q.size() == 0 && cpl_q.size() == 0) break;
            @(negedge clk);
        end
        chk({name, "_sys_drained"}, 32'(sys_q.size()), 32'h0);
        chk({name, "_cpl_drained"}, 32'(cpl_q.size()), 32'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_cycle_logs();
        strobe_cyc_q.delete();
        ready_cyc_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- directed tests ----------------
    initial begin
        int base_sys, base_rdy, n;
        rst = 1'b0;
        req0_strobe = 1'b0; req0_rw = 1'b0; req0_address = '0; req0_data_in = '0;
        req1_strobe = 1'b0; req1_rw = 1'b0; req1_address = '0; req1_data_in = '0;
        exp_dout[0] = '0; exp_dout[1] = '0;

        mem[16'h0012] = 32'h1122_3344;
        mem[16'h0020] = 32'h5555_AAAA;
        mem[16'h0045] = 32'h4545_0045;
        mem[16'h0076] = 32'h7676_0076;
        mem[16'h0A00] = 32'hA0A0_0001;
        mem[16'h0B00] = 32'hB0B0_0002;
        mem[16'h0059] = 32'h5959_5959;
        mem[16'h0066] = 32'h6666_6666;

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_strobe_ready_err", {29'b0, sysstrobe, req0_ready | req1_ready, timeout_err}, 32'h0);
        chk("rst_data_out0", req0_data_out, 32'h0);
        chk("rst_data_out1", req1_data_out, 32'h0);
        chk("rst_sysaddress", 32'(sysaddress), 32'h0);

        // single read, memory responds 3 cycles after sysstrobe
        mem_delay = 3;
        exp_sys(1'b1, 16'h0012, '0);
        exp_cpl(1'b0, 1'b1, 32'h1122_3344, 1'b0);
        strobe(1'b0, 1'b1, 16'h0012, 32'h0);
        drain("single_read");

        // req1 read at minimum latency, then write leaves data_out intact
        mem_delay = 1;
        clear_cycle_logs();
        exp_sys(1'b1, 16'h0020, '0);
        exp_cpl(1'b1, 1'b1, 32'h5555_AAAA, 1'b0);
        strobe(1'b1, 1'b1, 16'h0020, 32'h0);
        drain("min_latency");
        chk("strobe_latency", 32'(strobe_cyc_q.size() > 0 ? strobe_cyc_q[0] - issue_cyc : -1), 32'd2);
        chk("ready_latency", 32'(ready_cyc_q.size() > 0 ? ready_cyc_q[0] - issue_cyc : -1), 32'd4);

        exp_sys(1'b0, 16'h0099, 32'hA123_B456);
        exp_cpl(1'b1, 1'b0, '0, 1'b0);
        strobe(1'b1, 1'b0, 16'h0099, 32'hA123_B456);
        drain("write");
        chk("mem_written", mem_rd(16'h0099), 32'hA123_B456);
        chk("req0_out_kept", req0_data_out, 32'h1122_3344);

        // simultaneous strobes after reset: req0 first, second issue 2 cycles after first DONE
        do_reset();
        mem_delay = 2;
        clear_cycle_logs();
        base_sys = n_sys;
        exp_sys(1'b1, 16'h0045, '0);
        exp_sys(1'b1, 16'h0076, '0);
        exp_cpl(1'b0, 1'b1, 32'h4545_0045, 1'b0);
        exp_cpl(1'b1, 1'b1, 32'h7676_0076, 1'b0);
        @(negedge clk);
        req0_strobe = 1'b1; req0_rw = 1'b1; req0_address = 16'h0045;
        req1_strobe = 1'b1; req1_rw = 1'b1; req1_address = 16'h0076;
        @(negedge clk);
        req0_strobe = 1'b0; req1_strobe = 1'b0;
        drain("simultaneous");
        chk("simul_sys_count", 32'(n_sys - base_sys), 32'd2);
        if (strobe_cyc_q.size() >= 2 && ready_cyc_q.size() >= 1)
            chk("issue_gap", 32'(strobe_cyc_q[1] - ready_cyc_q[0]), 32'd2);
        else
            chk("issue_gap_samples", 32'(strobe_cyc_q.size()), 32'd2);

        // continuous re-strobing by both: grants alternate 0,1,0,1,0,1
        for (int i = 0; i < 3; i++) begin
            exp_sys(1'b1, 16'h0A00, '0);
            exp_cpl(1'b0, 1'b1, 32'hA0A0_0001, 1'b0);
            exp_sys(1'b1, 16'h0B00, '0);
            exp_cpl(1'b1, 1'b1, 32'hB0B0_0002, 1'b0);
        end
        base_sys = n_sys;
        @(negedge clk);
        req0_strobe = 1'b1; req0_rw = 1'b1; req0_address = 16'h0A00;
        req1_strobe = 1'b1; req1_rw = 1'b1; req1_address = 16'h0B00;
        // after the 4th completion both third requests are latched
        n = 0;
        for (int i = 0; i < 400 && n < 4; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) n++;
        end
        @(negedge clk);
        req0_strobe = 1'b0; req1_strobe = 1'b0;
        drain("round_robin");
        repeat (10) @(negedge clk);
        chk("rr_sys_count", 32'(n_sys - base_sys), 32'd6);

        // dropped strobe while pending
        mem_delay = 4;
        base_sys = n_sys;
        exp_sys(1'b1, 16'h0059, '0);
        exp_cpl(1'b0, 1'b1, 32'h5959_5959, 1'b0);
        strobe(1'b0, 1'b1, 16'h0059, 32'h0);
        strobe(1'b0, 1'b1, 16'h0066, 32'h0);
        drain("dropped");
        repeat (10) @(negedge clk);
        chk("dropped_sys_count", 32'(n_sys - base_sys), 32'd1);
        chk("bus_stable_in_wait", 32'(stable_err), 32'h0);

        // stray sysready while IDLE is ignored
        base_rdy = n_rdy;
        manual_data  = 32'h0BAD_0BAD;
        manual_pulse = 1'b1;
        repeat (6) @(negedge clk);
        chk("stray_sysready", 32'(n_rdy - base_rdy), 32'h0);

        // reset while in WAIT, then sysready: no completion
        mem_auto = 1'b0;
        base_rdy = n_rdy;
        exp_sys(1'b1, 16'h0033, '0);
        strobe(1'b0, 1'b1, 16'h0033, 32'h0);
        for (int i = 0; i < 20 && sys_q.size() != 0; i++) @(negedge clk);
        chk("rstwait_issued", 32'(sys_q.size()), 32'h0);
        do_reset();
        manual_data  = 32'h1357_9BDF;
        manual_pulse = 1'b1;
        repeat (8) @(negedge clk);
        chk("rstwait_no_ready", 32'(n_rdy - base_rdy), 32'h0);
        chk("rstwait_data_out0", req0_data_out, 32'h0);
        chk("rstwait_sysaddress", 32'(sysaddress), 32'h0);

`ifdef TIMEOUT_EN
        // watchdog: 15 WAIT cycles then DEADBEEF with timeout_err
        clear_cycle_logs();
        exp_sys(1'b1, 16'h0077, '0);
        exp_cpl(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        strobe(1'b0, 1'b1, 16'h0077, 32'h0);
        drain("timeout");
        if (strobe_cyc_q.size() > 0 && ready_cyc_q.size() > 0)
            chk("timeout_latency", 32'(ready_cyc_q[0] - strobe_cyc_q[0]), 32'd16);
        else
            chk("timeout_samples", 32'(ready_cyc_q.size()), 32'd1);
`else
        // without the watchdog WAIT is unbounded
        base_rdy = n_rdy;
        exp_sys(1'b1, 16'h0077, '0);
        strobe(1'b0, 1'b1, 16'h0077, 32'h0);
        repeat (40) @(negedge clk);
        chk("unbounded_wait", 32'(n_rdy - base_rdy), 32'h0);
        exp_cpl(1'b0, 1'b1, 32'h600D_F00D, 1'b0);
        manual_data  = 32'h600D_F00D;
        manual_pulse = 1'b1;
        drain("late_ready");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
